// File: rtl/tdp_ram_pkg.sv
// Shared sizing for the text-screen cell store: default word geometry and
// the byte-lane count helper used by the interface and the RAM.
package tdp_ram_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 14;
  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned BYTE_WIDTH_DEF = 8;
  localparam int unsigned NB_DEF         = DATA_WIDTH_DEF / BYTE_WIDTH_DEF;

  function automatic int unsigned nb_lanes(input int unsigned dw, input int unsigned bw);
    return dw / bw;
  endfunction

endpackage

// File: rtl/tdp_byte_ram_if.sv
// Bundle of both RAM ports (A = CPU/bus side, B = video fetch side).
// The RAM takes the slave view; the bus/video masters drive the master view.
interface tdp_byte_ram_if
  import tdp_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BYTE_WIDTH = BYTE_WIDTH_DEF
);

  localparam int unsigned NB = nb_lanes(DATA_WIDTH, BYTE_WIDTH);

  logic                  ena_i;
  logic [NB-1:0]         wea_i;
  logic [ADDR_WIDTH-1:0] addra_i;
  logic [DATA_WIDTH-1:0] dina_i;
  logic                  regcea_i;
  logic [DATA_WIDTH-1:0] douta_o;

  logic                  enb_i;
  logic [NB-1:0]         web_i;
  logic [ADDR_WIDTH-1:0] addrb_i;
  logic [DATA_WIDTH-1:0] dinb_i;
  logic                  regceb_i;
  logic [DATA_WIDTH-1:0] doutb_o;

  modport slave (
    input  ena_i, wea_i, addra_i, dina_i, regcea_i,
    input  enb_i, web_i, addrb_i, dinb_i, regceb_i,
    output douta_o, doutb_o
  );

  modport master (
    output ena_i, wea_i, addra_i, dina_i, regcea_i,
    output enb_i, web_i, addrb_i, dinb_i, regceb_i,
    input  douta_o, doutb_o
  );

endinterface

// File: rtl/tdp_ram_rdpipe.sv
// Per-port read output pipeline: stage 1 captures the array word on a pure
// read, stage 2 (latency 2 only) follows stage 1 under regce.
module tdp_ram_rdpipe #(
  parameter int unsigned           DATA_WIDTH   = 64,
  parameter int unsigned           READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  regce_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] stage1_q, stage1_d;
  logic [DATA_WIDTH-1:0] stage2_q, stage2_d;
  logic                  rd_flag_q;

  // Writes and idle cycles leave stage 1 alone so dout keeps the last read data
  always_comb begin
    stage1_d = stage1_q;
    stage2_d = stage2_q;
    if (rd_en_i) begin
      stage1_d = rd_data_i;
    end else begin
      stage1_d = stage1_q;
    end
    if (regce_i && rd_flag_q) begin
      stage2_d = stage1_q;
    end else begin
      stage2_d = stage2_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage1_q  <= RESET_VALUE;
      stage2_q  <= RESET_VALUE;
      rd_flag_q <= 1'b0;
    end else begin
      stage1_q  <= stage1_d;
      stage2_q  <= stage2_d;
      rd_flag_q <= rd_en_i;
    end
  end

  assign dout_o = (READ_LATENCY == 32'd1) ? stage1_q : stage2_q;

endmodule

// File: rtl/tdp_byte_ram.sv
// True dual-port byte-writable RAM backing the text-screen cell store.
// Both ports share clk_i; reads see pre-edge contents, port A wins write collisions.
module tdp_byte_ram
  import tdp_ram_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int unsigned           DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned           BYTE_WIDTH     = BYTE_WIDTH_DEF,
  parameter int unsigned           READ_LATENCY_A = 2,
  parameter int unsigned           READ_LATENCY_B = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  tdp_byte_ram_if.slave bus
);

  localparam int unsigned NB    = nb_lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  if ((READ_LATENCY_A != 32'd1) && (READ_LATENCY_A != 32'd2)) begin : g_bad_lat_a
    $error("tdp_byte_ram: READ_LATENCY_A must be 1 or 2");
  end
  if ((READ_LATENCY_B != 32'd1) && (READ_LATENCY_B != 32'd2)) begin : g_bad_lat_b
    $error("tdp_byte_ram: READ_LATENCY_B must be 1 or 2");
  end
  if ((DATA_WIDTH % BYTE_WIDTH) != 32'd0) begin : g_bad_width
    $error("tdp_byte_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;
  logic                  rd_en_a, rd_en_b;

  // Port B lanes are written first so port A overrides any lane both ports hit
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NB; k++) begin
      if (bus.enb_i && bus.web_i[k]) begin
        mem_q[bus.addrb_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dinb_i[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    for (int unsigned k = 0; k < NB; k++) begin
      if (bus.ena_i && bus.wea_i[k]) begin
        mem_q[bus.addra_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dina_i[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rd_word_a = mem_q[bus.addra_i];
  assign rd_word_b = mem_q[bus.addrb_i];
  assign rd_en_a   = bus.ena_i && (bus.wea_i == {NB{1'b0}});
  assign rd_en_b   = bus.enb_i && (bus.web_i == {NB{1'b0}});

  tdp_ram_rdpipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY_A),
    .RESET_VALUE (RESET_VALUE)
  ) u_rdpipe_a (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_en_i  (rd_en_a),
    .rd_data_i(rd_word_a),
    .regce_i  (bus.regcea_i),
    .dout_o   (bus.douta_o)
  );

  tdp_ram_rdpipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY_B),
    .RESET_VALUE (RESET_VALUE)
  ) u_rdpipe_b (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_en_i  (rd_en_b),
    .rd_data_i(rd_word_b),
    .regce_i  (bus.regceb_i),
    .dout_o   (bus.doutb_o)
  );

endmodule

// File: tb/tb_tdp_byte_ram.sv
// Scoreboard bench for tdp_byte_ram: directed scenarios plus random traffic,
// checked against a word-array reference model of the dual-port RAM.
module tb_tdp_byte_ram;
  import tdp_ram_pkg::*;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  logic clk;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];

  logic [63:0] mdl_mem [int unsigned];
  logic [63:0] a_s1, a_out, b_out;
  logic        a_prev_rd;
  logic [63:0] word5;

  tdp_byte_ram_if bus ();

  tdp_byte_ram dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end (got timeout, expected finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_rd(input int unsigned ad);
    return mdl_mem.exists(ad) ? mdl_mem[ad] : 64'h0;
  endfunction

  function automatic void mem_wr(input int unsigned ad, input logic [NB_DEF-1:0] we,
                                 input logic [63:0] din);
    logic [63:0] w;
    w = mem_rd(ad);
    for (int k = 0; k < 8; k++) if (we[k]) w[k*8 +: 8] = din[k*8 +: 8];
    mdl_mem[ad] = w;
  endfunction

  // Reference: old data on reads, B then A writes, A output lags one more edge under regce
  task automatic model_edge();
    logic rda, rdb;
    logic [63:0] old_a, old_b;
    exp_t e;
    if (rst) begin
      a_s1 = 64'h0; a_out = 64'h0; b_out = 64'h0; a_prev_rd = 1'b0;
    end else begin
      rda   = bus.ena_i && (bus.wea_i == 8'h00);
      rdb   = bus.enb_i && (bus.web_i == 8'h00);
      old_a = mem_rd(bus.addra_i);
      old_b = mem_rd(bus.addrb_i);
      if (bus.regcea_i && a_prev_rd) a_out = a_s1;
      if (rda) a_s1 = old_a;
      a_prev_rd = rda;
      if (rdb) b_out = old_b;
      if (bus.enb_i) mem_wr(bus.addrb_i, bus.web_i, bus.dinb_i);
      if (bus.ena_i) mem_wr(bus.addra_i, bus.wea_i, bus.dina_i);
    end
    e.a = a_out;
    e.b = b_out;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  // Monitor: every cycle after an edge the DUT presents both outputs
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("douta", bus.douta_o, e.a);
      check("doutb", bus.doutb_o, e.b);
    end
  end

  task automatic idle();
    bus.ena_i = 1'b0; bus.wea_i = 8'h00; bus.addra_i = 14'd0; bus.dina_i = 64'h0; bus.regcea_i = 1'b1;
    bus.enb_i = 1'b0; bus.web_i = 8'h00; bus.addrb_i = 14'd0; bus.dinb_i = 64'h0; bus.regceb_i = 1'b1;
  endtask

  task automatic wr_a(input int unsigned ad, input logic [63:0] d, input logic [7:0] we);
    bus.ena_i = 1'b1; bus.wea_i = we; bus.addra_i = 14'(ad); bus.dina_i = d;
  endtask

  task automatic wr_b(input int unsigned ad, input logic [63:0] d, input logic [7:0] we);
    bus.enb_i = 1'b1; bus.web_i = we; bus.addrb_i = 14'(ad); bus.dinb_i = d;
  endtask

  task automatic rd_a(input int unsigned ad);
    bus.ena_i = 1'b1; bus.wea_i = 8'h00; bus.addra_i = 14'(ad);
  endtask

  task automatic rd_b(input int unsigned ad);
    bus.enb_i = 1'b1; bus.web_i = 8'h00; bus.addrb_i = 14'(ad);
  endtask

  initial begin
    a_s1 = 64'h0; a_out = 64'h0; b_out = 64'h0; a_prev_rd = 1'b0;
    idle();
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("reset_a", bus.douta_o, 64'h0);
    check("reset_b", bus.doutb_o, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    for (int i = 0; i < 16; i++) begin
      idle(); wr_a(i, {$urandom, $urandom}, 8'hFF); tick();
    end

    // Latency: B one edge, A two edges
    idle(); wr_a(3, 64'h0123_4567_89AB_CDEF, 8'hFF); tick();
    idle(); rd_a(3); rd_b(3); tick();
    check("lat_b", bus.doutb_o, 64'h0123_4567_89AB_CDEF);
    idle(); tick();
    check("lat_a", bus.douta_o, 64'h0123_4567_89AB_CDEF);

    // Byte enables
    idle(); wr_a(7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF); tick();
    idle(); wr_a(7, 64'h0, 8'b0000_0101); tick();
    idle(); rd_b(7); tick();
    check("byte_en", bus.doutb_o, 64'hFFFF_FFFF_FF00_FF00);

    // no_change on port B
    idle(); wr_a(1, 64'h11, 8'hFF); tick();
    idle(); rd_b(1); tick();
    check("nochg_rd", bus.doutb_o, 64'h11);
    idle(); wr_b(2, 64'h22, 8'hFF); tick();
    check("nochg_wr", bus.doutb_o, 64'h11);
    idle(); wr_b(2, 64'h3300, 8'h02); tick();
    check("nochg_part", bus.doutb_o, 64'h11);
    idle(); rd_b(2); tick();
    check("nochg_new", bus.doutb_o, 64'h3322);

    // Cross-port collision, then dual write
    idle(); wr_a(9, 64'h55, 8'hFF); tick();
    idle(); wr_a(9, 64'hAA, 8'hFF); rd_b(9); tick();
    check("coll_old", bus.doutb_o, 64'h55);
    idle(); rd_b(9); tick();
    check("coll_new", bus.doutb_o, 64'hAA);
    idle(); wr_a(9, 64'h1, 8'hFF); wr_b(9, 64'h2, 8'hFF); tick();
    idle(); rd_b(9); tick();
    check("dual_wr", bus.doutb_o, 64'h1);

    // regce hold on port A while reads keep streaming
    word5 = 64'hDEAD_BEEF_CAFE_0005;
    idle(); wr_a(5, word5, 8'hFF); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); rd_a(5); bus.regcea_i = 1'b0; tick();
      check("regce_hold", bus.douta_o, 64'h0123_4567_89AB_CDEF);
    end
    idle(); rd_a(5); bus.regcea_i = 1'b1; tick();
    check("regce_load", bus.douta_o, word5);

    // Mid-run reset with a read in flight on A
    idle(); rd_a(3); rd_b(3); tick();
    idle();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    a_s1 = 64'h0; a_out = 64'h0; b_out = 64'h0; a_prev_rd = 1'b0;
    check("rst_mid_a", bus.douta_o, 64'h0);
    check("rst_mid_b", bus.doutb_o, 64'h0);
    tick();
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle(); tick();
    check("rst_lost", bus.douta_o, 64'h0);
    idle(); rd_a(5); rd_b(5); tick();
    check("rst_keep_b", bus.doutb_o, word5);
    idle(); tick();
    check("rst_keep_a", bus.douta_o, word5);

    // Random traffic on a small address window
    for (int i = 0; i < 300; i++) begin
      idle();
      bus.ena_i    = ($urandom_range(3) != 0);
      bus.wea_i    = ($urandom_range(2) == 0) ? 8'($urandom) : 8'h00;
      bus.addra_i  = 14'($urandom_range(15));
      bus.dina_i   = {$urandom, $urandom};
      bus.regcea_i = ($urandom_range(3) != 0);
      bus.enb_i    = ($urandom_range(3) != 0);
      bus.web_i    = ($urandom_range(2) == 0) ? 8'($urandom) : 8'h00;
      bus.addrb_i  = 14'($urandom_range(15));
      bus.dinb_i   = {$urandom, $urandom};
      bus.regceb_i = 1'($urandom);
      tick();
    end

    idle(); tick();
    idle(); tick();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
